// File: rtl/accu_pkg.sv
// Shared constants and helpers for the window-accumulator datapath and its output FIFO.
package accu_pkg;

    localparam int unsigned ACC_IN_W   = 37;
    localparam int unsigned ACC_W      = ACC_IN_W + 1;
    localparam int unsigned WIN_LEN    = 50;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned DROP_CNT_W = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int unsigned FIFO_AW = clog2(FIFO_DEPTH);

    // Occupancy update selected each cycle from the write/load pair.
    typedef enum logic [1:0] {
        CntHold,
        CntInc,
        CntDec
    } cnt_op_e;

endpackage

// File: rtl/accu_fifo_ram.sv
// FIFO storage array: synchronous write, asynchronous read.
module accu_fifo_ram #(
    parameter int unsigned DATA_W = 38,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/accu_window_fifo.sv
// Captures one accumulator window sum per acc_valid rising edge and presents it FWFT,
// dropping (and counting) words that arrive while the storage is full.
module accu_window_fifo
    import accu_pkg::*;
#(
    parameter int unsigned DATA_W = ACC_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned AW     = clog2(DEPTH),
    parameter int unsigned DROP_W = DROP_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] acc_dout,
    input  logic              acc_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [AW+1:0]     level,
    output logic              full,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              clr_ovf
);

    logic              acc_valid_q;
    logic              wr_pulse;
    logic              wr_en;
    logic              drop;
    logic              load;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       mem_count;
    logic [DATA_W-1:0] rd_data;
    cnt_op_e           cnt_op;

    assign wr_pulse = acc_valid & ~acc_valid_q;
    // full reflects the pre-edge count, so a pop in the same cycle cannot make room.
    assign full     = (mem_count == (AW+1)'(DEPTH));
    assign wr_en    = wr_pulse & ~full;
    assign drop     = wr_pulse & full;
    assign load     = (mem_count != '0) & (~m_valid | m_ready);
    assign level    = {1'b0, mem_count} + (AW+2)'(m_valid);

    always_comb begin
        cnt_op = CntHold;
        unique case ({wr_en, load})
            2'b10:   cnt_op = CntInc;
            2'b01:   cnt_op = CntDec;
            default: cnt_op = CntHold;
        endcase
    end

    accu_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .we     (wr_en),
        .waddr  (wr_ptr),
        .wdata  (acc_dout),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_valid_q <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_count   <= '0;
        end else begin
            acc_valid_q <= acc_valid;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case (cnt_op)
                CntInc:  mem_count <= mem_count + (AW+1)'(1);
                CntDec:  mem_count <= mem_count - (AW+1)'(1);
                default: mem_count <= mem_count;
            endcase
        end
    end

    // FWFT output register; holds its word while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (load) begin
            m_data  <= rd_data;
            m_valid <= 1'b1;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // A drop in the same cycle as clr_ovf wins: the counter restarts at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= DROP_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_accu_window_fifo.sv
// Directed bench: expected words go into a scoreboard queue, a negedge monitor pops and compares.
module tb_accu_window_fifo;

    localparam int unsigned DATA_W = 38;
    localparam int unsigned AW     = 4;
    localparam int unsigned DROP_W = 8;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] acc_dout;
    logic              acc_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [AW+1:0]     level;
    logic              full;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic              clr_ovf;

    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] exp_word;
    int n_cmp;
    int n_err;

    accu_window_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (16),
        .AW     (AW),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_dout  (acc_dout),
        .acc_valid (acc_valid),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .level     (level),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle acc_valid pulse followed by one idle cycle.
    task automatic pulse(input logic [DATA_W-1:0] value, input bit expect_store);
        acc_dout  = value;
        acc_valid = 1'b1;
        if (expect_store) sb.push_back(value);
        tick();
        acc_valid = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %0d, expected no word at %0t", m_data, $time);
            end else begin
                exp_word = sb.pop_front();
                check("m_data", 64'(m_data), 64'(exp_word));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        acc_dout  = '0;
        acc_valid = 1'b0;
        m_ready   = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) tick();

        check("rst_m_valid",  64'(m_valid),  64'd0);
        check("rst_m_data",   64'(m_data),   64'd0);
        check("rst_level",    64'(level),    64'd0);
        check("rst_full",     64'(full),     64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // 1: single word, written at edge k, visible at k+1, consumed at k+2
        m_ready   = 1'b1;
        acc_dout  = 38'd5;
        acc_valid = 1'b1;
        sb.push_back(38'd5);
        tick();
        check("t1_m_valid_k",  64'(m_valid), 64'd0);
        check("t1_level_k",    64'(level),   64'd1);
        acc_valid = 1'b0;
        tick();
        check("t1_m_valid_k1", 64'(m_valid), 64'd1);
        check("t1_m_data_k1",  64'(m_data),  64'd5);
        tick();
        check("t1_level_end",  64'(level),   64'd0);
        check("t1_m_valid_end", 64'(m_valid), 64'd0);

        // 2: level-held acc_valid writes one signed word
        m_ready   = 1'b0;
        acc_dout  = -38'sd7;
        acc_valid = 1'b1;
        sb.push_back(-38'sd7);
        repeat (10) tick();
        acc_valid = 1'b0;
        repeat (3) tick();
        check("t2_level",  64'(level),  64'd1);
        check("t2_m_data", 64'(m_data), 64'h3F_FFFF_FFF9);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("t2_level_end", 64'(level), 64'd0);

        // 3: fill to 17 words (16 stored + output register), then one drop
        for (int i = 1; i <= 17; i++) pulse(DATA_W'(i), 1'b1);
        check("t3_level",    64'(level),    64'd17);
        check("t3_full",     64'(full),     64'd1);
        check("t3_overflow", 64'(overflow), 64'd0);
        check("t3_drop_cnt", 64'(drop_cnt), 64'd0);
        pulse(38'd18, 1'b0);
        check("t3_ovf_set",  64'(overflow), 64'd1);
        check("t3_drop_one", 64'(drop_cnt), 64'd1);
        check("t3_level_kept", 64'(level),  64'd17);

        // 4: drain on consecutive cycles across the pointer wrap
        m_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            check("t4_m_valid_streaming", 64'(m_valid), 64'd1);
            tick();
        end
        m_ready = 1'b0;
        check("t4_m_valid_end", 64'(m_valid), 64'd0);
        check("t4_level_end",   64'(level),   64'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t4_clr_overflow", 64'(overflow), 64'd0);
        check("t4_clr_drop_cnt", 64'(drop_cnt), 64'd0);

        // 5: pulse against a full memory while popping still drops
        for (int i = 101; i <= 117; i++) pulse(DATA_W'(i), 1'b1);
        m_ready   = 1'b1;
        acc_dout  = 38'd999;
        acc_valid = 1'b1;
        tick();
        check("t5_drop_cnt", 64'(drop_cnt), 64'd1);
        check("t5_overflow", 64'(overflow), 64'd1);
        check("t5_level",    64'(level),    64'd16);
        check("t5_full_after_pop", 64'(full), 64'd0);
        m_ready   = 1'b0;
        acc_valid = 1'b0;
        tick();
        pulse(38'd118, 1'b1);
        check("t5_full_again", 64'(full), 64'd1);
        m_ready   = 1'b1;
        acc_dout  = 38'd998;
        acc_valid = 1'b1;
        clr_ovf   = 1'b1;
        tick();
        check("t5_clr_drop_cnt", 64'(drop_cnt), 64'd1);
        check("t5_clr_overflow", 64'(overflow), 64'd1);
        m_ready   = 1'b0;
        acc_valid = 1'b0;
        clr_ovf   = 1'b0;
        tick();

        // 6: reset with words held
        m_ready = 1'b1;
        repeat (7) tick();
        m_ready = 1'b0;
        check("t6_level_pre",   64'(level),   64'd9);
        check("t6_m_valid_pre", 64'(m_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("t6_m_valid", 64'(m_valid),  64'd0);
        check("t6_m_data",  64'(m_data),   64'd0);
        check("t6_level",   64'(level),    64'd0);
        check("t6_full",    64'(full),     64'd0);
        check("t6_ovf",     64'(overflow), 64'd0);
        check("t6_drop",    64'(drop_cnt), 64'd0);
        acc_dout  = 38'd42;
        acc_valid = 1'b1;
        sb.push_back(38'd42);
        tick();
        check("t6_m_valid_k", 64'(m_valid), 64'd0);
        acc_valid = 1'b0;
        tick();
        check("t6_m_valid_k1", 64'(m_valid), 64'd1);
        check("t6_m_data_k1",  64'(m_data),  64'd42);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
